// File: rtl/hamming_pkg.sv
// Shared Hamming(8,4) SECDED definitions: code word layout, error classes and parity helpers.
// Used by both the encoder and the decoder.
package hamming_pkg;

  typedef enum logic [1:0] {
    SIN_ERROR = 2'd0,
    CORREGIDO = 2'd1,
    DOBLE     = 2'd2
  } estado_err_t;

  typedef logic [2:0] sindrome_t;

  // Bit index k of the code word holds Hamming position k+1; p0 covers the whole word
  localparam int POS_P1 = 0;
  localparam int POS_P2 = 1;
  localparam int POS_D1 = 2;
  localparam int POS_P4 = 3;
  localparam int POS_D2 = 4;
  localparam int POS_D3 = 5;
  localparam int POS_D4 = 6;
  localparam int POS_P0 = 7;

  function automatic logic paridad8(input logic [7:0] v);
    return ^v;
  endfunction

  // Flips the data bit addressed by a syndrome; parity positions leave the data untouched
  function automatic logic [3:0] corregir_dato(input logic [3:0] dato, input sindrome_t s);
    logic [3:0] r;
    r = dato;
    case (s)
      3'd3:    r[0] = ~dato[0];
      3'd5:    r[1] = ~dato[1];
      3'd6:    r[2] = ~dato[2];
      3'd7:    r[3] = ~dato[3];
      default: r = dato;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/hamming_sindrome.sv
// Combinational syndrome {c4,c2,c1} and global parity of an 8-bit Hamming SECDED code word.
module hamming_sindrome
  import hamming_pkg::*;
(
  input  logic [7:0] palabra,
  output sindrome_t  sindrome,
  output logic       paridad_global
);

  assign sindrome = {
    palabra[POS_P4] ^ palabra[POS_D2] ^ palabra[POS_D3] ^ palabra[POS_D4],
    palabra[POS_P2] ^ palabra[POS_D1] ^ palabra[POS_D3] ^ palabra[POS_D4],
    palabra[POS_P1] ^ palabra[POS_D1] ^ palabra[POS_D2] ^ palabra[POS_D4]
  };

  assign paridad_global = paridad8(palabra);

endmodule

// File: rtl/decodificador_hamming.sv
// Hamming(8,4) SECDED decoder: two-stage elastic pipeline with valid/ready on both sides,
// saturating error counters and a sticky double-error flag.
module decodificador_hamming
  import hamming_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             reloj,
  input  logic             rst_n,
  input  logic [7:0]       palabra_in,
  input  logic             valido_in,
  output logic             listo_in,
  output logic [3:0]       dato_salida,
  output logic [1:0]       estado_error,
  output logic [2:0]       posicion_error,
  output logic             valido_out,
  input  logic             listo_out,
  input  logic             limpiar_cnt,
  output logic [CNT_W-1:0] cnt_corregidos,
  output logic [CNT_W-1:0] cnt_dobles,
  output logic             error_doble_pegajoso
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_UNO = {{(CNT_W-1){1'b0}}, 1'b1};

  sindrome_t   sindrome_s;
  logic        paridad_s;

  // Only the data bits are kept past S1; syndrome and parity carry the rest of the word
  logic        v1_r;
  logic [3:0]  dato1_r;
  sindrome_t   sindrome1_r;
  logic        paridad1_r;

  logic        v2_r;
  logic [3:0]  dato2_r;
  estado_err_t estado2_r;
  sindrome_t   pos2_r;

  logic        avanza2_s;
  logic        carga1_s;
  logic        carga2_s;
  logic        hs_out_s;

  logic [3:0]  dato_corr_s;
  estado_err_t estado_s;
  sindrome_t   pos_s;

  logic [CNT_W-1:0] cnt_corr_r;
  logic [CNT_W-1:0] cnt_dob_r;
  logic             pegajoso_r;

  hamming_sindrome u_sindrome (
    .palabra        (palabra_in),
    .sindrome       (sindrome_s),
    .paridad_global (paridad_s)
  );

  // Handshake and pipeline advance conditions
  always_comb begin
    avanza2_s = ~v2_r | listo_out;
    listo_in  = ~v1_r | avanza2_s;
    carga1_s  = valido_in & listo_in;
    carga2_s  = v1_r & avanza2_s;
    hs_out_s  = v2_r & listo_out;
  end

  // Stage 1: capture data bits, syndrome and global parity on input handshake
  always_ff @(posedge reloj or negedge rst_n) begin
    if (!rst_n) begin
      v1_r        <= 1'b0;
      dato1_r     <= 4'd0;
      sindrome1_r <= 3'd0;
      paridad1_r  <= 1'b0;
    end else begin
      if (carga1_s) begin
        v1_r        <= 1'b1;
        dato1_r     <= {palabra_in[POS_D4], palabra_in[POS_D3], palabra_in[POS_D2], palabra_in[POS_D1]};
        sindrome1_r <= sindrome_s;
        paridad1_r  <= paridad_s;
      end else if (avanza2_s) begin
        v1_r <= 1'b0;
      end
    end
  end

  // Classification from syndrome and global parity
  always_comb begin
    estado_s    = SIN_ERROR;
    pos_s       = 3'd0;
    dato_corr_s = dato1_r;
    case ({sindrome1_r != 3'd0, paridad1_r})
      2'b00: begin
        estado_s = SIN_ERROR;
      end
      2'b01: begin
        estado_s = CORREGIDO;
      end
      2'b11: begin
        estado_s    = CORREGIDO;
        pos_s       = sindrome1_r;
        dato_corr_s = corregir_dato(dato1_r, sindrome1_r);
      end
      2'b10: begin
        estado_s = DOBLE;
        pos_s    = sindrome1_r;
      end
      default: begin
        estado_s = SIN_ERROR;
      end
    endcase
  end

  // Stage 2: output bundle, held while downstream stalls
  always_ff @(posedge reloj or negedge rst_n) begin
    if (!rst_n) begin
      v2_r      <= 1'b0;
      dato2_r   <= 4'd0;
      estado2_r <= SIN_ERROR;
      pos2_r    <= 3'd0;
    end else begin
      if (avanza2_s) begin
        v2_r <= v1_r;
      end
      if (carga2_s) begin
        dato2_r   <= dato_corr_s;
        estado2_r <= estado_s;
        pos2_r    <= pos_s;
      end
    end
  end

  // Statistics: counted once per output handshake, clear wins over a same-cycle update
  always_ff @(posedge reloj or negedge rst_n) begin
    if (!rst_n) begin
      cnt_corr_r <= '0;
      cnt_dob_r  <= '0;
      pegajoso_r <= 1'b0;
    end else if (limpiar_cnt) begin
      cnt_corr_r <= '0;
      cnt_dob_r  <= '0;
      pegajoso_r <= 1'b0;
    end else if (hs_out_s) begin
      case (estado2_r)
        CORREGIDO: begin
          if (cnt_corr_r != CNT_MAX) begin
            cnt_corr_r <= cnt_corr_r + CNT_UNO;
          end
        end
        DOBLE: begin
          if (cnt_dob_r != CNT_MAX) begin
            cnt_dob_r <= cnt_dob_r + CNT_UNO;
          end
          pegajoso_r <= 1'b1;
        end
        default: begin
          pegajoso_r <= pegajoso_r;
        end
      endcase
    end
  end

  assign valido_out           = v2_r;
  assign dato_salida          = dato2_r;
  assign estado_error         = estado2_r;
  assign posicion_error       = pos2_r;
  assign cnt_corregidos       = cnt_corr_r;
  assign cnt_dobles           = cnt_dob_r;
  assign error_doble_pegajoso = pegajoso_r;

endmodule

// File: tb/tb_decodificador_hamming.sv
// Self-checking bench for decodificador_hamming: scoreboard against a nearest-code-word model,
// with a second instance at CNT_W=2 sharing the stimulus to exercise counter saturation.
module tb_decodificador_hamming;

  logic       reloj = 1'b0;
  logic       rst_n;
  logic [7:0] palabra_in;
  logic       valido_in;
  logic       listo_out;
  logic       limpiar_cnt;

  logic       listo_in, valido_out, pegajoso;
  logic [3:0] dato_salida;
  logic [1:0] estado_error;
  logic [2:0] posicion_error;
  logic [7:0] cnt_corr, cnt_dob;

  logic       listo_in2, valido_out2, pegajoso2;
  logic [3:0] dato_salida2;
  logic [1:0] estado_error2;
  logic [2:0] posicion_error2;
  logic [1:0] cnt_corr2, cnt_dob2;

  int n_checks = 0;
  int n_fails  = 0;

  logic [8:0] esp_q[$];
  logic [7:0] stim_q[$];
  int         m_corr = 0, m_dob = 0, m_corr2 = 0, m_dob2 = 0;
  logic       m_peg = 1'b0;
  logic       hold_v = 1'b0;
  logic [8:0] hold_val;

  always #5 reloj = ~reloj;

  decodificador_hamming #(.CNT_W(8)) dut (
    .reloj(reloj), .rst_n(rst_n), .palabra_in(palabra_in), .valido_in(valido_in),
    .listo_in(listo_in), .dato_salida(dato_salida), .estado_error(estado_error),
    .posicion_error(posicion_error), .valido_out(valido_out), .listo_out(listo_out),
    .limpiar_cnt(limpiar_cnt), .cnt_corregidos(cnt_corr), .cnt_dobles(cnt_dob),
    .error_doble_pegajoso(pegajoso)
  );

  decodificador_hamming #(.CNT_W(2)) dut2 (
    .reloj(reloj), .rst_n(rst_n), .palabra_in(palabra_in), .valido_in(valido_in),
    .listo_in(listo_in2), .dato_salida(dato_salida2), .estado_error(estado_error2),
    .posicion_error(posicion_error2), .valido_out(valido_out2), .listo_out(listo_out),
    .limpiar_cnt(limpiar_cnt), .cnt_corregidos(cnt_corr2), .cnt_dobles(cnt_dob2),
    .error_doble_pegajoso(pegajoso2)
  );

  task automatic verificar(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] codificar(input logic [3:0] d);
    logic [7:0] cw;
    cw[2] = d[0];
    cw[4] = d[1];
    cw[5] = d[2];
    cw[6] = d[3];
    cw[0] = d[0] ^ d[1] ^ d[3];
    cw[1] = d[0] ^ d[2] ^ d[3];
    cw[3] = d[1] ^ d[2] ^ d[3];
    cw[7] = ^cw[6:0];
    return cw;
  endfunction

  // Expected {dato[3:0], estado[1:0], posicion[2:0]} by searching the nearest valid code word
  function automatic logic [8:0] modelo(input logic [7:0] w);
    logic [7:0] cw, dif;
    logic [2:0] syn;
    for (int d = 0; d < 16; d++) begin
      cw  = codificar(4'(d));
      dif = cw ^ w;
      if ($countones(dif) == 0) return {4'(d), 2'd0, 3'd0};
      if ($countones(dif) == 1) begin
        if (dif[7]) return {4'(d), 2'd1, 3'd0};
        for (int k = 0; k < 7; k++)
          if (dif[k]) return {4'(d), 2'd1, 3'(k + 1)};
      end
    end
    syn = 3'd0;
    for (int k = 0; k < 7; k++)
      if (w[k]) syn = syn ^ 3'(k + 1);
    return {w[6], w[5], w[4], w[2], 2'd2, syn};
  endfunction

  // Monitor: counters, stall stability, scoreboard pop/push, counter model
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge reloj);
      if (!rst_n) begin
        hold_v = 1'b0;
      end else begin
        verificar("cnt_corr", 32'(cnt_corr), 32'(m_corr));
        verificar("cnt_dob", 32'(cnt_dob), 32'(m_dob));
        verificar("pegajoso", 32'(pegajoso), 32'(m_peg));
        verificar("cnt_corr_w2", 32'(cnt_corr2), 32'(m_corr2));
        verificar("cnt_dob_w2", 32'(cnt_dob2), 32'(m_dob2));
        verificar("pegajoso_w2", 32'(pegajoso2), 32'(m_peg));
        if (hold_v)
          verificar("estable", 32'({valido_out, dato_salida, estado_error, posicion_error}),
                    32'({1'b1, hold_val}));
        hold_v   = valido_out && !listo_out;
        hold_val = {dato_salida, estado_error, posicion_error};
        e = 9'd0;
        if (valido_out && listo_out) begin
          if (esp_q.size() == 0) begin
            verificar("sb_sobra", 32'd1, 32'd0);
          end else begin
            e = esp_q.pop_front();
            verificar("salida", 32'({dato_salida, estado_error, posicion_error}), 32'(e));
          end
        end
        if (limpiar_cnt) begin
          m_corr = 0; m_dob = 0; m_corr2 = 0; m_dob2 = 0; m_peg = 1'b0;
        end else if (valido_out && listo_out) begin
          if (e[4:3] == 2'd1) begin
            if (m_corr < 255) m_corr++;
            if (m_corr2 < 3) m_corr2++;
          end else if (e[4:3] == 2'd2) begin
            if (m_dob < 255) m_dob++;
            if (m_dob2 < 3) m_dob2++;
            m_peg = 1'b1;
          end
        end
        if (valido_in && listo_in) esp_q.push_back(modelo(palabra_in));
      end
    end
  end

  // Streams stim_q; modo 0 = fixed stall window, modo 1 = random downstream ready
  task automatic drive_all(input int modo, input int stall_ini, input int stall_len);
    int c = 0;
    logic acc;
    while ((stim_q.size() > 0 || esp_q.size() > 0) && c < 500) begin
      if (modo == 0) listo_out = !(c >= stall_ini && c < stall_ini + stall_len);
      else           listo_out = ($urandom_range(0, 3) != 0);
      valido_in  = (stim_q.size() > 0);
      palabra_in = valido_in ? stim_q[0] : 8'h00;
      @(negedge reloj);
      acc = valido_in && listo_in;
      if (modo == 0 && stall_len > 0 && c == stall_ini + 1)
        verificar("listo_in_lleno", 32'(listo_in), 32'd0);
      @(posedge reloj);
      #1;
      if (acc) void'(stim_q.pop_front());
      c++;
    end
    valido_in = 1'b0;
    listo_out = 1'b1;
    if (c >= 500) verificar("timeout_stream", 32'd0, 32'd1);
  endtask

  // Single word through an empty pipeline; called at posedge+1
  task automatic latencia(input logic [7:0] w, input logic [3:0] dato_esp);
    verificar("listo_in_vacio", 32'(listo_in), 32'd1);
    listo_out  = 1'b1;
    valido_in  = 1'b1;
    palabra_in = w;
    @(posedge reloj); #1;
    valido_in = 1'b0;
    verificar("lat_ciclo1", 32'(valido_out), 32'd0);
    @(posedge reloj); #1;
    verificar("lat_ciclo2", 32'(valido_out), 32'd1);
    verificar("lat_dato", 32'(dato_salida), 32'(dato_esp));
    @(posedge reloj); #1;
    verificar("lat_vacio", 32'(valido_out), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; palabra_in = 8'h00; valido_in = 1'b0; listo_out = 1'b1; limpiar_cnt = 1'b0;
    #1;
    verificar("rst_valido_out", 32'(valido_out), 32'd0);
    verificar("rst_listo_in", 32'(listo_in), 32'd1);
    verificar("rst_bundle", 32'({dato_salida, estado_error, posicion_error}), 32'd0);
    verificar("rst_cnts", 32'({cnt_corr, cnt_dob, pegajoso}), 32'd0);
    #11 rst_n = 1'b1;
    @(posedge reloj); #1;

    latencia(8'hD2, 4'b1010);
    latencia(8'h99, 4'b0010);

    stim_q = '{8'hC2, 8'h52, 8'hD1};
    drive_all(0, 0, 0);
    @(posedge reloj); #1;
    verificar("corr_tras_c2_52", 32'(cnt_corr), 32'd2);
    verificar("dob_tras_d1", 32'(cnt_dob), 32'd1);
    verificar("peg_tras_d1", 32'(pegajoso), 32'd1);

    stim_q = '{8'hD2, 8'hC2, 8'h99, 8'hD1};
    drive_all(0, 2, 3);

    stim_q = '{8'hC2, 8'hC2, 8'hC2, 8'hC2, 8'hC2};
    drive_all(0, 0, 0);
    @(posedge reloj); #1;
    verificar("corr_w8", 32'(cnt_corr), 32'd8);
    verificar("corr_w2_sat", 32'(cnt_corr2), 32'd3);

    // DOBLE word parked at the output, then released together with limpiar_cnt
    listo_out = 1'b0; valido_in = 1'b1; palabra_in = 8'hD1;
    @(posedge reloj); #1;
    valido_in = 1'b0;
    @(posedge reloj); #1;
    verificar("doble_aparcado", 32'({valido_out, estado_error}), 32'({1'b1, 2'd2}));
    limpiar_cnt = 1'b1; listo_out = 1'b1;
    @(posedge reloj); #1;
    limpiar_cnt = 1'b0;
    verificar("limpiar_dob", 32'({cnt_dob, cnt_corr}), 32'd0);
    verificar("limpiar_peg", 32'({pegajoso, pegajoso2}), 32'd0);
    verificar("limpiar_w2", 32'({cnt_dob2, cnt_corr2}), 32'd0);

    for (int i = 0; i < 30; i++) stim_q.push_back(8'($urandom_range(0, 255)));
    drive_all(1, 0, 0);

    stim_q = '{8'hC2, 8'hD1};
    drive_all(0, 0, 0);
    @(posedge reloj); #1;

    // Fill both stages, then reset asynchronously mid-cycle
    listo_out = 1'b0; valido_in = 1'b1; palabra_in = 8'h99;
    repeat (3) @(posedge reloj);
    #1;
    verificar("ambos_llenos", 32'({valido_out, listo_in}), 32'({1'b1, 1'b0}));
    #2 rst_n = 1'b0;
    #1;
    verificar("arst_valido_out", 32'(valido_out), 32'd0);
    verificar("arst_listo_in", 32'(listo_in), 32'd1);
    verificar("arst_cnts", 32'({cnt_corr, cnt_dob, pegajoso}), 32'd0);
    verificar("arst_bundle", 32'({dato_salida, estado_error, posicion_error}), 32'd0);
    valido_in = 1'b0; listo_out = 1'b1;
    esp_q.delete();
    m_corr = 0; m_dob = 0; m_corr2 = 0; m_dob2 = 0; m_peg = 1'b0;
    @(negedge reloj); #2 rst_n = 1'b1;
    @(posedge reloj); #1;
    latencia(8'hC2, 4'b1010);
    @(posedge reloj); #1;
    verificar("post_rst_corr", 32'(cnt_corr), 32'd1);
    verificar("sb_vacio", 32'(esp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
